shake_core_arbiter: RTL and testbench



---
 rtl/shake_arb_pkg.sv | 29 ++
 rtl/shake_rr_pick.sv | 31 +++
 rtl/shake_core_arbiter.sv | 158 +++++++++++++++
 tb/tb_shake_core_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/shake_arb_pkg.sv
// Shared types and constants for the SHAKE core arbiter slice.
package shake_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OWN   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam int SHA3_ADDR_W     = 7;
    localparam int SHA3_DATA_W     = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    // Watchdog counter width: enough for the limit, clamped to 8..16 bits.
    function automatic int wd_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/shake_rr_pick.sv
// Combinational rotate-priority picker: first request after last_owner wins.
module shake_rr_pick
    import shake_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_owner,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Scan farthest-first so the nearest requester after last_owner overwrites.
    always_comb begin : p_pick
        int                 cand;
        logic [IDX_W-1:0]   cand_idx;
        cand     = 0;
        cand_idx = '0;
        o_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(i_last_owner) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            o_idx    = i_req[cand_idx] ? cand_idx : o_idx;
        end
        o_valid  = |i_req;
        o_onehot = o_valid ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/shake_core_arbiter.sv
// Round-robin owner arbiter for a single shared sha3 core port.
// Optional watchdog revoke enabled by defining SHAKE_ARB_TIMEOUT_EN.
module shake_core_arbiter
    import shake_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = SHA3_ADDR_W,
    parameter int DATA_W         = SHA3_DATA_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [NUM_REQ-1:0]        rq_w,
    input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
    input  logic [NUM_REQ*DATA_W-1:0] rq_din,
    input  logic [NUM_REQ-1:0]        rq_init,
    input  logic [NUM_REQ-1:0]        rq_next,
    output logic [NUM_REQ-1:0]        rq_ready,
    output logic [DATA_W-1:0]         rq_dout,
    output logic                      core_w,
    output logic [ADDR_W-1:0]         core_addr,
    output logic [DATA_W-1:0]         core_din,
    output logic                      core_init,
    output logic                      core_next,
    input  logic                      core_ready,
    input  logic [DATA_W-1:0]         core_dout,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_last_owner, w_last_nxt;
    logic               r_timeout_err, w_terr_nxt;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_owner_req;
    logic               w_owner_strobe;
    logic               w_revoke;

    shake_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_onehot     (w_pick_onehot),
        .o_idx        (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    assign w_owner_req    = |(req & r_gnt);
    assign w_owner_strobe = |((rq_w | rq_init | rq_next) & r_gnt);

`ifdef SHAKE_ARB_TIMEOUT_EN
    localparam int CNT_W = wd_cnt_w(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             w_wd_tick;

    assign w_wd_tick = (r_state == OWN) && core_ready && !w_owner_strobe;
    assign w_revoke  = w_wd_tick && w_owner_req && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts idle-but-ready owner cycles, cleared by any owner strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if ((r_state != OWN) || w_owner_strobe || w_revoke) begin
            r_wd_cnt <= '0;
        end else if (w_wd_tick) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end else begin
            r_wd_cnt <= r_wd_cnt;
        end
    end
`else
    assign w_revoke = 1'b0;
`endif

    // Next-state and grant logic; req drop by owner takes precedence over revoke.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last_owner;
        w_terr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_last_nxt  = w_pick_idx;
                    w_state_nxt = GRANT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: w_state_nxt = core_ready ? OWN : GRANT;
            OWN: begin
                if (!w_owner_req) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else if (w_revoke) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = DRAIN;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_state_nxt = OWN;
                end
            end
            DRAIN: w_state_nxt = core_ready ? IDLE : DRAIN;
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_last_owner  <= IDX_W'(NUM_REQ - 1);
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_last_owner  <= w_last_nxt;
            r_timeout_err <= w_terr_nxt;
        end
    end

    // Core port mux: the registered one-hot grant masks every client lane.
    always_comb begin
        core_w    = 1'b0;
        core_addr = '0;
        core_din  = '0;
        core_init = 1'b0;
        core_next = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            core_w    = core_w    | (rq_w[i]    & r_gnt[i]);
            core_init = core_init | (rq_init[i] & r_gnt[i]);
            core_next = core_next | (rq_next[i] & r_gnt[i]);
            core_addr = core_addr | (rq_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{r_gnt[i]}});
            core_din  = core_din  | (rq_din[i*DATA_W +: DATA_W]  & {DATA_W{r_gnt[i]}});
        end
    end

    assign gnt         = r_gnt;
    assign rq_ready    = r_gnt & {NUM_REQ{core_ready}};
    assign rq_dout     = core_dout;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_shake_core_arbiter.sv
// Directed bench: 2-client instance for grant/mux/drain/reset, 3-client instance for fairness.
module tb_shake_core_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, gnt, rq_w, rq_init, rq_next, rq_ready;
    logic [13:0] rq_addr;
    logic [63:0] rq_din;
    logic [31:0] rq_dout, core_din, core_dout;
    logic [6:0]  core_addr;
    logic        core_w, core_init, core_next, core_ready, busy, timeout_err;

    logic [2:0]  t3_req, t3_gnt, t3_rq_ready;
    logic [31:0] t3_rq_dout, t3_core_din;
    logic [6:0]  t3_core_addr;
    logic        t3_core_w, t3_core_init, t3_core_next, t3_busy, t3_terr;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [1:0]  w;
        logic [13:0] addr;
        logic [63:0] din;
        logic [1:0]  init;
        logic [1:0]  nxt;
        logic        rdy;
        logic        e_w;
        logic [6:0]  e_addr;
        logic [31:0] e_din;
        logic        e_init;
        logic        e_next;
        logic [1:0]  e_ready;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    shake_core_arbiter #(.NUM_REQ(2), .ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rq_w(rq_w), .rq_addr(rq_addr),
        .rq_din(rq_din), .rq_init(rq_init), .rq_next(rq_next), .rq_ready(rq_ready),
        .rq_dout(rq_dout), .core_w(core_w), .core_addr(core_addr), .core_din(core_din),
        .core_init(core_init), .core_next(core_next), .core_ready(core_ready),
        .core_dout(core_dout), .busy(busy), .timeout_err(timeout_err)
    );

    shake_core_arbiter #(.NUM_REQ(3), .ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(255)) dut3 (
        .clk(clk), .rst(rst), .req(t3_req), .gnt(t3_gnt), .rq_w(3'b000), .rq_addr(21'd0),
        .rq_din(96'd0), .rq_init(3'b000), .rq_next(3'b000), .rq_ready(t3_rq_ready),
        .rq_dout(t3_rq_dout), .core_w(t3_core_w), .core_addr(t3_core_addr),
        .core_din(t3_core_din), .core_init(t3_core_init), .core_next(t3_core_next),
        .core_ready(1'b1), .core_dout(32'd0), .busy(t3_busy), .timeout_err(t3_terr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{2'b01, {7'h00, 7'h05}, {32'h0, 32'hDEADBEEF}, 2'b00, 2'b00, 1'b1,
                    1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 1'b0, 2'b01};
        vecs[1] = '{2'b10, {7'h7F, 7'h05}, {32'h12345678, 32'hDEADBEEF}, 2'b01, 2'b00, 1'b1,
                    1'b0, 7'h05, 32'hDEADBEEF, 1'b1, 1'b0, 2'b01};
        vecs[2] = '{2'b10, {7'h33, 7'h00}, {32'hCAFEF00D, 32'h0}, 2'b10, 2'b10, 1'b1,
                    1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 2'b01};
        vecs[3] = '{2'b00, {7'h00, 7'h7F}, {32'h0, 32'hFFFFFFFF}, 2'b00, 2'b01, 1'b1,
                    1'b0, 7'h7F, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b01};
        vecs[4] = '{2'b00, 14'h0, 64'h0, 2'b00, 2'b00, 1'b0,
                    1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 2'b00};
        vecs[5] = '{2'b11, {7'h15, 7'h2A}, {32'h11111111, 32'h0BADF00D}, 2'b00, 2'b00, 1'b1,
                    1'b1, 7'h2A, 32'h0BADF00D, 1'b0, 1'b0, 2'b01};

        rst = 1'b1; req = 2'b11; rq_w = 2'b00; rq_addr = 14'h0; rq_din = 64'h0;
        rq_init = 2'b00; rq_next = 2'b00; core_ready = 1'b1; core_dout = 32'h0;
        t3_req = 3'b000;
        tick(); tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_core", {core_w, core_init, core_next, core_addr, core_din}, 0);

        rst = 1'b0;
        tick();
        chk("first_gnt", gnt, 2'b01);
        chk("grant_busy", busy, 1'b1);
        tick();

        // Table-driven mux checks while client 0 owns the core.
        for (int v = 0; v < 6; v++) begin
            rq_w = vecs[v].w; rq_addr = vecs[v].addr; rq_din = vecs[v].din;
            rq_init = vecs[v].init; rq_next = vecs[v].nxt; core_ready = vecs[v].rdy;
            core_dout = 32'hA5A50000 + 32'(v);
            #2;
            chk($sformatf("vec%0d_w", v), core_w, vecs[v].e_w);
            chk($sformatf("vec%0d_addr", v), core_addr, vecs[v].e_addr);
            chk($sformatf("vec%0d_din", v), core_din, vecs[v].e_din);
            chk($sformatf("vec%0d_init", v), core_init, vecs[v].e_init);
            chk($sformatf("vec%0d_next", v), core_next, vecs[v].e_next);
            chk($sformatf("vec%0d_ready", v), rq_ready, vecs[v].e_ready);
            chk($sformatf("vec%0d_dout", v), rq_dout, 32'hA5A50000 + 32'(v));
            tick();
        end
        rq_w = 2'b00; rq_init = 2'b00; rq_next = 2'b00; core_ready = 1'b1;

        // Client 0 releases: DRAIN, IDLE, then client 1.
        req = 2'b10;
        #2 chk("drop_same_cycle_gnt", gnt, 2'b01);
        tick();
        chk("drain_gnt", gnt, 2'b00);
        chk("drain_busy", busy, 1'b1);
        rq_init = 2'b11; rq_next = 2'b11;
        #2 chk("drain_no_strobe", {core_init, core_next}, 2'b00);
        rq_init = 2'b00; rq_next = 2'b00;
        tick();
        chk("idle_gnt", gnt, 2'b00);
        chk("idle_busy", busy, 1'b0);
        tick();
        chk("second_gnt", gnt, 2'b10);
        tick();

        // Client 1 releases while core is still busy for 24 cycles.
        core_ready = 1'b0; req = 2'b00;
        tick();
        req = 2'b01;
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("stall%0d_busy", c), busy, 1'b1);
            chk($sformatf("stall%0d_gnt", c), gnt, 2'b00);
            tick();
        end
        core_ready = 1'b1;
        tick();
        chk("post_stall_idle", gnt, 2'b00);
        tick();
        chk("post_stall_gnt", gnt, 2'b01);
        tick();

        // Reset while client 0 owns and pulses init.
        req = 2'b11; rq_init = 2'b01;
        #2 chk("pre_rst_init", core_init, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", gnt, 2'b00);
        chk("mid_rst_init", core_init, 1'b0);
        rst = 1'b0; rq_init = 2'b00;
        tick();
        chk("after_rst_gnt", gnt, 2'b01);
        tick();

`ifdef SHAKE_ARB_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("wd%0d_gnt", c), gnt, 2'b01);
            chk($sformatf("wd%0d_terr", c), timeout_err, 1'b0);
            tick();
        end
        tick();
        chk("wd_revoke_gnt", gnt, 2'b00);
        chk("wd_revoke_terr", timeout_err, 1'b1);
        tick();
        chk("wd_terr_pulse", timeout_err, 1'b0);
        tick();
        chk("wd_next_gnt", gnt, 2'b10);
`else
        for (int c = 0; c < 20; c++) tick();
        chk("hold_gnt", gnt, 2'b01);
        chk("hold_terr", timeout_err, 1'b0);
`endif
        req = 2'b00;
        tick(); tick(); tick();

        // Fairness on the 3-client instance with all requests held.
        t3_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 20 && t3_gnt == 3'b000; c++) begin
                chk("fair_onehot0", 64'($onehot0(t3_gnt)), 64'd1);
                tick();
            end
            chk($sformatf("fair_txn%0d", k), t3_gnt, 3'b001 << (k % 3));
            tick();
            chk("fair_own_onehot", 64'($onehot(t3_gnt)), 64'd1);
            t3_req = ~t3_gnt;
            tick();
            t3_req = 3'b111;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
